// File: rtl/musa_pkg.sv
// Shared MUSA core definitions.
// Holds the ALU flag codes (used by both the ALU producer and the
// flag/branch consumer), the BRFL opcode and the flag/branch FSM states.
package musa_pkg;

  // 3-bit ALU flag codes; 110 and 111 are reserved.
  localparam logic [2:0] FLAG_NONE      = 3'b000;
  localparam logic [2:0] FLAG_EQUAL     = 3'b001;
  localparam logic [2:0] FLAG_EXCEPTION = 3'b010;
  localparam logic [2:0] FLAG_OVERFLOW  = 3'b011;
  localparam logic [2:0] FLAG_UNDERFLOW = 3'b100;
  localparam logic [2:0] FLAG_ABOVE     = 3'b101;

  // Branch-on-flag opcode as seen by decode.
  localparam logic [5:0] OP_BRFL = 6'h2a;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FLAG = 2'd1,
    ST_RESOLVE   = 2'd2,
    ST_FLUSH     = 2'd3
  } fbu_state_e;

endpackage

// File: rtl/branch_target_adder.sv
// Combinational branch target: pc + 4 + (sign_extend(offset) << 2).
// Wraps modulo 2^ADDR_W. Shared with the fetch stage.
// Ports:
//   pc     - PC of the branch instruction
//   offset - signed word offset
//   target - redirect address
// Assumes ADDR_W > OFF_W.
module branch_target_adder #(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] off_ext;

  assign off_ext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign target  = pc + ADDR_W'(4) + (off_ext << 2);

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register + BRFL branch resolver at the consumer end of the EX-stage
// ALU flag interface.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   flag_we, flag_in      - ALU flag write
//   flag_busy             - flag producer in flight ahead of the branch
//   exc_clear             - clears exc_sticky
//   br_valid/br_ready     - BRFL request handshake (cond, pc, offset)
//   res_valid/taken/target- registered resolution (valid is a 1-cycle pulse)
//   flush                 - fetch/decode squash, FLUSH_CYCLES long on taken
//   flag_q, exc_sticky    - architectural flag state
module flag_branch_unit
  import musa_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int OFF_W        = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flag_we,
  input  logic [2:0]        flag_in,
  input  logic              flag_busy,
  input  logic              exc_clear,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [OFF_W-1:0]  br_offset,
  output logic              res_valid,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  output logic              flush,
  output logic [2:0]        flag_q,
  output logic              exc_sticky
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  fbu_state_e        state, state_n;
  logic [2:0]        cond_q;
  logic [ADDR_W-1:0] pc_q;
  logic [OFF_W-1:0]  off_q;
  logic [CNT_W-1:0]  flush_cnt;
  logic              xfer;
  logic              taken;
  logic [OFF_W-1:0]  off_sel;
  logic [ADDR_W-1:0] tgt;

  assign br_ready = (state == ST_IDLE);
  assign xfer     = br_valid && br_ready;
  // Reserved codes 110/111 can sit in flag_q but an in-range cond never equals them.
  assign taken    = (cond_q == flag_q);
  // Not-taken redirect is pc + 4: feed a zero offset through the same adder.
  assign off_sel  = taken ? off_q : '0;

  branch_target_adder #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) u_tgt (
    .pc     (pc_q),
    .offset (off_sel),
    .target (tgt)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:      if (xfer) state_n = (flag_busy || flag_we) ? ST_WAIT_FLAG : ST_RESOLVE;
      ST_WAIT_FLAG: if (!flag_busy && !flag_we) state_n = ST_RESOLVE;
      ST_RESOLVE:   state_n = taken ? ST_FLUSH : ST_IDLE;
      ST_FLUSH:     if (flush_cnt == '0) state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      flag_q     <= FLAG_NONE;
      exc_sticky <= 1'b0;
      res_valid  <= 1'b0;
      res_taken  <= 1'b0;
      res_target <= '0;
      flush      <= 1'b0;
      flush_cnt  <= '0;
      cond_q     <= '0;
      pc_q       <= '0;
      off_q      <= '0;
    end else begin
      state     <= state_n;
      res_valid <= (state == ST_RESOLVE);
      // flush tracks the FLUSH state, so it rises together with res_valid.
      flush     <= (state_n == ST_FLUSH);

      if (flag_we) flag_q <= flag_in;

      // Set beats clear.
      if (flag_we && flag_in == FLAG_EXCEPTION) exc_sticky <= 1'b1;
      else if (exc_clear)                       exc_sticky <= 1'b0;

      if (xfer) begin
        cond_q <= br_cond;
        pc_q   <= br_pc;
        off_q  <= br_offset;
      end

      if (state == ST_RESOLVE) begin
        res_taken  <= taken;
        res_target <= tgt;
        flush_cnt  <= CNT_W'(FLUSH_CYCLES - 1);
      end else if (state == ST_FLUSH && flush_cnt != '0) begin
        flush_cnt  <= flush_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit. Inputs are driven and outputs
// sampled on the falling edge; each tick() is one clock cycle.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        flag_we;
  logic [2:0]  flag_in;
  logic        flag_busy;
  logic        exc_clear;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic [31:0] br_pc;
  logic [15:0] br_offset;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        flush;
  logic [2:0]  flag_q;
  logic        exc_sticky;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  flag_branch_unit #(.ADDR_W(32), .OFF_W(16), .FLUSH_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .flag_we    (flag_we),
    .flag_in    (flag_in),
    .flag_busy  (flag_busy),
    .exc_clear  (exc_clear),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_cond    (br_cond),
    .br_pc      (br_pc),
    .br_offset  (br_offset),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_target (res_target),
    .flush      (flush),
    .flag_q     (flag_q),
    .exc_sticky (exc_sticky)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; flag_we = 1'b0; flag_in = 3'b000; flag_busy = 1'b0;
    exc_clear = 1'b0; br_valid = 1'b0; br_cond = 3'b000; br_pc = '0; br_offset = '0;
    tick(); tick();
    total_cnt++; if (flag_q !== 3'b000) $display("FAIL reset_flag_q got %h exp 0", flag_q); else pass_cnt++;
    total_cnt++; if (exc_sticky !== 1'b0) $display("FAIL reset_exc got %b exp 0", exc_sticky); else pass_cnt++;
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %b exp 0", res_valid); else pass_cnt++;
    total_cnt++; if (res_taken !== 1'b0) $display("FAIL reset_res_taken got %b exp 0", res_taken); else pass_cnt++;
    total_cnt++; if (res_target !== 32'h0) $display("FAIL reset_res_target got %h exp 0", res_target); else pass_cnt++;
    total_cnt++; if (flush !== 1'b0) $display("FAIL reset_flush got %b exp 0", flush); else pass_cnt++;
    total_cnt++; if (br_ready !== 1'b1) $display("FAIL reset_br_ready got %b exp 1", br_ready); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_taken();
    flag_we = 1'b1; flag_in = 3'b001;
    tick();
    flag_we = 1'b0;
    total_cnt++; if (flag_q !== 3'b001) $display("FAIL tk_flag_q got %h exp 1", flag_q); else pass_cnt++;
    br_valid = 1'b1; br_cond = 3'b001; br_pc = 32'h100; br_offset = 16'h0004;
    total_cnt++; if (br_ready !== 1'b1) $display("FAIL tk_ready_pre got %b exp 1", br_ready); else pass_cnt++;
    tick(); // transfer edge
    br_valid = 1'b0;
    total_cnt++; if (br_ready !== 1'b0) $display("FAIL tk_ready_c1 got %b exp 0", br_ready); else pass_cnt++;
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL tk_valid_c1 got %b exp 0", res_valid); else pass_cnt++;
    tick();
    total_cnt++; if (res_valid !== 1'b1) $display("FAIL tk_valid got %b exp 1", res_valid); else pass_cnt++;
    total_cnt++; if (res_taken !== 1'b1) $display("FAIL tk_taken got %b exp 1", res_taken); else pass_cnt++;
    total_cnt++; if (res_target !== 32'h114) $display("FAIL tk_target got %h exp 114", res_target); else pass_cnt++;
    total_cnt++; if (flush !== 1'b1) $display("FAIL tk_flush1 got %b exp 1", flush); else pass_cnt++;
    total_cnt++; if (br_ready !== 1'b0) $display("FAIL tk_ready_f1 got %b exp 0", br_ready); else pass_cnt++;
    tick();
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL tk_valid_pulse got %b exp 0", res_valid); else pass_cnt++;
    total_cnt++; if (flush !== 1'b1) $display("FAIL tk_flush2 got %b exp 1", flush); else pass_cnt++;
    total_cnt++; if (br_ready !== 1'b0) $display("FAIL tk_ready_f2 got %b exp 0", br_ready); else pass_cnt++;
    tick();
    total_cnt++; if (flush !== 1'b0) $display("FAIL tk_flush_end got %b exp 0", flush); else pass_cnt++;
    total_cnt++; if (br_ready !== 1'b1) $display("FAIL tk_ready_end got %b exp 1", br_ready); else pass_cnt++;
    total_cnt++; if (res_target !== 32'h114) $display("FAIL tk_target_hold got %h exp 114", res_target); else pass_cnt++;
  endtask

  task automatic test_not_taken();
    flag_we = 1'b1; flag_in = 3'b101;
    tick();
    flag_we = 1'b0;
    br_valid = 1'b1; br_cond = 3'b001; br_pc = 32'h200; br_offset = 16'h0010;
    tick();
    br_valid = 1'b0;
    total_cnt++; if (flush !== 1'b0) $display("FAIL nt_flush_c1 got %b exp 0", flush); else pass_cnt++;
    tick();
    total_cnt++; if (res_valid !== 1'b1) $display("FAIL nt_valid got %b exp 1", res_valid); else pass_cnt++;
    total_cnt++; if (res_taken !== 1'b0) $display("FAIL nt_taken got %b exp 0", res_taken); else pass_cnt++;
    total_cnt++; if (res_target !== 32'h204) $display("FAIL nt_target got %h exp 204", res_target); else pass_cnt++;
    total_cnt++; if (flush !== 1'b0) $display("FAIL nt_flush got %b exp 0", flush); else pass_cnt++;
    tick();
    total_cnt++; if (br_ready !== 1'b1) $display("FAIL nt_ready got %b exp 1", br_ready); else pass_cnt++;
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL nt_valid_pulse got %b exp 0", res_valid); else pass_cnt++;
    total_cnt++; if (flush !== 1'b0) $display("FAIL nt_flush2 got %b exp 0", flush); else pass_cnt++;
    total_cnt++; if (res_target !== 32'h204) $display("FAIL nt_target_hold got %h exp 204", res_target); else pass_cnt++;
  endtask

  // Two back-to-back taken branches exercising target wrap-around.
  task automatic test_wrap();
    br_valid = 1'b1; br_cond = 3'b101; br_pc = 32'h0; br_offset = 16'hffff;
    tick();
    br_valid = 1'b0;
    tick();
    total_cnt++; if (res_taken !== 1'b1) $display("FAIL wr1_taken got %b exp 1", res_taken); else pass_cnt++;
    total_cnt++; if (res_target !== 32'h0) $display("FAIL wr1_target got %h exp 0", res_target); else pass_cnt++;
    tick(); tick();
    br_valid = 1'b1; br_cond = 3'b101; br_pc = 32'hffff_fffc; br_offset = 16'h0000;
    total_cnt++; if (br_ready !== 1'b1) $display("FAIL wr2_ready got %b exp 1", br_ready); else pass_cnt++;
    tick();
    br_valid = 1'b0;
    tick();
    total_cnt++; if (res_valid !== 1'b1) $display("FAIL wr2_valid got %b exp 1", res_valid); else pass_cnt++;
    total_cnt++; if (res_target !== 32'h0) $display("FAIL wr2_target got %h exp 0", res_target); else pass_cnt++;
    tick(); tick();
  endtask

  task automatic test_hazard();
    br_valid = 1'b1; br_cond = 3'b001; br_pc = 32'h300; br_offset = 16'h0002;
    flag_busy = 1'b1;
    tick(); // transfer while busy
    // A new request presented while not ready must be ignored.
    br_cond = 3'b000; br_pc = 32'hdead_0000;
    total_cnt++; if (br_ready !== 1'b0) $display("FAIL hz_ready got %b exp 0", br_ready); else pass_cnt++;
    tick();
    br_valid = 1'b0;
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL hz_valid_b1 got %b exp 0", res_valid); else pass_cnt++;
    flag_we = 1'b1; flag_in = 3'b001;
    tick();
    flag_we = 1'b0; flag_busy = 1'b0;
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL hz_valid_b2 got %b exp 0", res_valid); else pass_cnt++;
    tick();
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL hz_valid_res got %b exp 0", res_valid); else pass_cnt++;
    tick();
    total_cnt++; if (res_valid !== 1'b1) $display("FAIL hz_valid got %b exp 1", res_valid); else pass_cnt++;
    total_cnt++; if (res_taken !== 1'b1) $display("FAIL hz_taken got %b exp 1", res_taken); else pass_cnt++;
    total_cnt++; if (res_target !== 32'h30c) $display("FAIL hz_target got %h exp 30c", res_target); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (br_ready !== 1'b1) $display("FAIL hz_ready_end got %b exp 1", br_ready); else pass_cnt++;
  endtask

  task automatic test_sticky();
    flag_we = 1'b1; flag_in = 3'b010;
    tick();
    total_cnt++; if (exc_sticky !== 1'b1) $display("FAIL st_set got %b exp 1", exc_sticky); else pass_cnt++;
    exc_clear = 1'b1;
    tick();
    total_cnt++; if (exc_sticky !== 1'b1) $display("FAIL st_set_wins got %b exp 1", exc_sticky); else pass_cnt++;
    flag_we = 1'b0;
    tick();
    exc_clear = 1'b0;
    total_cnt++; if (exc_sticky !== 1'b0) $display("FAIL st_clear got %b exp 0", exc_sticky); else pass_cnt++;
  endtask

  task automatic test_reserved();
    flag_we = 1'b1; flag_in = 3'b110;
    tick();
    flag_we = 1'b0;
    total_cnt++; if (flag_q !== 3'b110) $display("FAIL rs_flag_q got %h exp 6", flag_q); else pass_cnt++;
    br_valid = 1'b1; br_cond = 3'b000; br_pc = 32'h400; br_offset = 16'h0008;
    tick();
    br_valid = 1'b0;
    tick();
    total_cnt++; if (res_valid !== 1'b1) $display("FAIL rs_valid got %b exp 1", res_valid); else pass_cnt++;
    total_cnt++; if (res_taken !== 1'b0) $display("FAIL rs_taken got %b exp 0", res_taken); else pass_cnt++;
    total_cnt++; if (res_target !== 32'h404) $display("FAIL rs_target got %h exp 404", res_target); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    br_valid = 1'b1; br_cond = 3'b110; br_pc = 32'h500; br_offset = 16'h0001;
    flag_busy = 1'b1;
    tick(); // into WAIT_FLAG
    br_valid = 1'b0;
    total_cnt++; if (br_ready !== 1'b0) $display("FAIL rm_wait got %b exp 0", br_ready); else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0; flag_busy = 1'b0;
    total_cnt++; if (br_ready !== 1'b1) $display("FAIL rm_ready got %b exp 1", br_ready); else pass_cnt++;
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL rm_valid got %b exp 0", res_valid); else pass_cnt++;
    total_cnt++; if (flush !== 1'b0) $display("FAIL rm_flush got %b exp 0", flush); else pass_cnt++;
    total_cnt++; if (flag_q !== 3'b000) $display("FAIL rm_flag_q got %h exp 0", flag_q); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++; if (res_valid !== 1'b0) $display("FAIL rm_no_res%0d got %b exp 0", i, res_valid); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_taken();
    test_not_taken();
    test_wrap();
    test_hazard();
    test_sticky();
    test_reserved();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
